// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the multi-port register file.
// Helpers work at maximum widths; callers extend/truncate to their own parameters.
package reg_file_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int MAX_DATA_W = 64;
  localparam int MAX_ADDR_W = 8;
  localparam int MAX_RD     = 4;

  typedef struct packed {
    logic                  hit;
    logic [MAX_DATA_W-1:0] data;
  } wr_res_t;

  // Extract port k's address from a packed address bus of aw-bit fields.
  function automatic logic [MAX_ADDR_W-1:0] addr_slice(
    input logic [MAX_RD*MAX_ADDR_W-1:0] bus,
    input int                           k,
    input int                           aw
  );
    logic [MAX_RD*MAX_ADDR_W-1:0] sh;
    sh = bus >> (k * aw);
    return sh[MAX_ADDR_W-1:0] & ({MAX_ADDR_W{1'b1}} >> (MAX_ADDR_W - aw));
  endfunction

  // Which write (if any) lands on address a this cycle; port 1 wins a tie.
  function automatic wr_res_t wr_resolve(
    input logic [MAX_ADDR_W-1:0] a,
    input logic                  we0,
    input logic [MAX_ADDR_W-1:0] waddr0,
    input logic [MAX_DATA_W-1:0] wdata0,
    input logic                  we1,
    input logic [MAX_ADDR_W-1:0] waddr1,
    input logic [MAX_DATA_W-1:0] wdata1,
    input logic                  zero_reg
  );
    wr_res_t r;
    r.hit  = 1'b0;
    r.data = '0;
    if (we1 && waddr1 == a) begin
      r.hit  = 1'b1;
      r.data = wdata1;
    end else if (we0 && waddr0 == a) begin
      r.hit  = 1'b1;
      r.data = wdata0;
    end
    if (zero_reg && a == '0) begin
      r.hit  = 1'b0;
      r.data = '0;
    end
    return r;
  endfunction
endpackage

// File: rtl/reg_file_scoreboard.sv
// Per-register pending flags: allocation sets, a write clears, allocation wins a tie.
module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1
)(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 alloc_en,
  input  logic [ADDR_W-1:0]    alloc_addr,
  input  logic [2**ADDR_W-1:0] clr_vec,
  output logic [2**ADDR_W-1:0] pending,
  output logic [2**ADDR_W-1:0] pending_nxt,
  output logic                 pending_any
);
  always_comb begin
    pending_nxt = pending;
    for (int a = 0; a < 2**ADDR_W; a++) begin
      if (clr_vec[a]) pending_nxt[a] = 1'b0;
      if (alloc_en && alloc_addr == ADDR_W'(a)) pending_nxt[a] = 1'b1;
      if (ZERO_REG != 0 && a == 0) pending_nxt[a] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending <= '0;
    else       pending <= pending_nxt;
  end

  assign pending_any = |pending;
endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: two prioritised write ports, NUM_RD registered read
// ports with optional write bypass, optional hardwired r0, pending scoreboard.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
)(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pending,
  input  logic                     alloc_en,
  input  logic [ADDR_W-1:0]        alloc_addr,
  output logic                     pending_any
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0]            mem [DEPTH];
  wr_res_t                      wr_vec [DEPTH];
  logic [DEPTH-1:0]             clr_vec;
  logic [DEPTH-1:0]             pending;
  logic [DEPTH-1:0]             pending_nxt;
  logic [MAX_RD*MAX_ADDR_W-1:0] rd_addr_ext;

  assign rd_addr_ext = (MAX_RD*MAX_ADDR_W)'(rd_addr);

  // Write resolution per address, shared by storage, scoreboard clear and bypass.
  always_comb begin
    for (int a = 0; a < DEPTH; a++) begin
      wr_vec[a]  = wr_resolve(MAX_ADDR_W'(a), we0, MAX_ADDR_W'(waddr0), MAX_DATA_W'(wdata0),
                              we1, MAX_ADDR_W'(waddr1), MAX_DATA_W'(wdata1), ZERO_REG != 0);
      clr_vec[a] = wr_vec[a].hit;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int a = 0; a < DEPTH; a++) mem[a] <= '0;
    end else begin
      for (int a = 0; a < DEPTH; a++)
        if (wr_vec[a].hit) mem[a] <= wr_vec[a].data[DATA_W-1:0];
    end
  end

  reg_file_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk         (clk),
    .reset       (reset),
    .alloc_en    (alloc_en),
    .alloc_addr  (alloc_addr),
    .clr_vec     (clr_vec),
    .pending     (pending),
    .pending_nxt (pending_nxt),
    .pending_any (pending_any)
  );

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [MAX_ADDR_W-1:0] addr_full;
    logic [ADDR_W-1:0]     addr;
    wr_res_t               byp;
    logic [DATA_W-1:0]     data_p0;
    logic                  pend_p0;
    logic [DATA_W-1:0]     data_p1;
    logic                  pend_p1;

    assign addr_full = addr_slice(rd_addr_ext, k, ADDR_W);
    assign addr      = addr_full[ADDR_W-1:0];
    assign byp       = wr_vec[addr];

    // Pending is sampled from the same side of the edge as the data.
    always_comb begin
      data_p0 = mem[addr];
      if (BYPASS != 0 && byp.hit) data_p0 = byp.data[DATA_W-1:0];
      if (ZERO_REG != 0 && addr == '0) data_p0 = '0;
      pend_p0 = (BYPASS != 0) ? pending_nxt[addr] : pending[addr];
    end

    // p0 -> p1: registered read output, held while the port is idle
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        data_p1 <= '0;
        pend_p1 <= 1'b0;
      end else if (rd_en[k]) begin
        data_p1 <= data_p0;
        pend_p1 <= pend_p0;
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = data_p1;
    assign rd_pending[k]               = pend_p1;
  end
endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: a bypassing and a non-bypassing instance share stimulus.
module tb_reg_file_mp;
  logic        clk = 1'b0;
  logic        reset;
  logic        we0, we1, alloc_en;
  logic [4:0]  waddr0, waddr1, alloc_addr;
  logic [31:0] wdata0, wdata1;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data_b, rd_data_n;
  logic [1:0]  rd_pend_b, rd_pend_n;
  logic        pany_b, pany_n;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  reg_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_pending(rd_pend_b),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .pending_any(pany_b)
  );

  reg_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(0), .ZERO_REG(1)) dut_nb (
    .clk(clk), .reset(reset),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_pending(rd_pend_n),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .pending_any(pany_n)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    we0 = 1'b0; waddr0 = '0; wdata0 = '0;
    we1 = 1'b0; waddr1 = '0; wdata1 = '0;
    alloc_en = 1'b0; alloc_addr = '0;
    rd_en = 2'b00; rd_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] en, input logic [4:0] a0, input logic [4:0] a1);
    rd_en = en;
    rd_addr = {a1, a0};
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick();
    chk("reset_rd_data_b", rd_data_b, 64'h0);
    chk("reset_rd_data_n", rd_data_n, 64'h0);
    chk("reset_rd_pend", {rd_pend_b, rd_pend_n}, 4'h0);
    chk("reset_pany", {pany_b, pany_n}, 2'b00);
    reset = 1'b0;

    // Plain writes then dual-port read
    we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'd100;
    tick();
    waddr0 = 5'd10; wdata0 = 32'd200;
    tick();
    idle(); rd(2'b11, 5'd5, 5'd10);
    tick();
    chk("rd_r5_r10_b", rd_data_b, {32'd200, 32'd100});
    chk("rd_r5_r10_n", rd_data_n, {32'd200, 32'd100});

    // Both write ports on r7, port 0 reads r7 in the same cycle
    idle(); rd(2'b01, 5'd7, 5'd0);
    we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11;
    we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h22;
    tick();
    chk("prio_bypass_b", rd_data_b, {32'd200, 32'h22});
    chk("prio_nobypass_n", rd_data_n, {32'd200, 32'h0});
    idle(); rd(2'b01, 5'd7, 5'd0);
    tick();
    chk("prio_later_b", rd_data_b[31:0], 32'h22);
    chk("prio_later_n", rd_data_n[31:0], 32'h22);

    // Distinct addresses on the two write ports
    idle();
    we0 = 1'b1; waddr0 = 5'd12; wdata0 = 32'hAA;
    we1 = 1'b1; waddr1 = 5'd13; wdata1 = 32'hBB;
    tick();
    idle(); rd(2'b11, 5'd12, 5'd13);
    tick();
    chk("dual_wr_b", rd_data_b, {32'hBB, 32'hAA});
    chk("dual_wr_n", rd_data_n, {32'hBB, 32'hAA});

    // Hardwired zero register
    idle(); rd(2'b01, 5'd0, 5'd0);
    we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFF;
    alloc_en = 1'b1; alloc_addr = 5'd0;
    tick();
    chk("r0_data_b", rd_data_b[31:0], 32'h0);
    chk("r0_pend_b", rd_pend_b[0], 1'b0);
    chk("r0_pany", {pany_b, pany_n}, 2'b00);
    idle(); rd(2'b01, 5'd0, 5'd0);
    tick();
    chk("r0_data_later_n", rd_data_n[31:0], 32'h0);
    chk("r0_pend_later", {rd_pend_b[0], rd_pend_n[0]}, 2'b00);
    chk("r0_pany_later", {pany_b, pany_n}, 2'b00);

    // Scoreboard: alloc, read pending, clear by write, alloc+write tie
    idle(); alloc_en = 1'b1; alloc_addr = 5'd3;
    tick();
    chk("alloc_pany", {pany_b, pany_n}, 2'b11);
    idle(); rd(2'b01, 5'd3, 5'd0);
    tick();
    chk("alloc_rd_pend", {rd_pend_b[0], rd_pend_n[0]}, 2'b11);
    idle(); rd(2'b01, 5'd3, 5'd0);
    we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'd5;
    tick();
    chk("clr_data_b", rd_data_b[31:0], 32'd5);
    chk("clr_pend_b", rd_pend_b[0], 1'b0);
    chk("clr_data_n", rd_data_n[31:0], 32'd0);
    chk("clr_pend_n", rd_pend_n[0], 1'b1);
    chk("clr_pany", {pany_b, pany_n}, 2'b00);
    idle(); rd(2'b01, 5'd3, 5'd0);
    alloc_en = 1'b1; alloc_addr = 5'd3;
    we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'd6;
    tick();
    chk("tie_data_b", rd_data_b[31:0], 32'd6);
    chk("tie_pend_b", rd_pend_b[0], 1'b1);
    chk("tie_data_n", rd_data_n[31:0], 32'd5);
    chk("tie_pend_n", rd_pend_n[0], 1'b0);
    chk("tie_pany", {pany_b, pany_n}, 2'b11);
    idle(); rd(2'b11, 5'd3, 5'd3);
    tick();
    chk("same_addr_data_b", rd_data_b, {32'd6, 32'd6});
    chk("same_addr_pend", {rd_pend_b, rd_pend_n}, 4'hF);

    // Read enable low holds outputs
    idle(); rd(2'b01, 5'd9, 5'd0);
    tick();
    chk("r9_first_b", rd_data_b[31:0], 32'd0);
    idle(); rd(2'b00, 5'd9, 5'd0);
    we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'd77;
    tick();
    chk("hold_data_b", rd_data_b, {32'd6, 32'd0});
    chk("hold_data_n", rd_data_n, {32'd6, 32'd0});
    chk("hold_pend", {rd_pend_b, rd_pend_n}, 4'b1010);
    idle(); rd(2'b01, 5'd9, 5'd0);
    tick();
    chk("reen_data_b", rd_data_b[31:0], 32'd77);
    chk("reen_data_n", rd_data_n[31:0], 32'd77);

    // Asynchronous reset between edges
    idle(); alloc_en = 1'b1; alloc_addr = 5'd20;
    tick();
    idle();
    #2;
    reset = 1'b1;
    #1;
    chk("areset_data_b", rd_data_b, 64'h0);
    chk("areset_data_n", rd_data_n, 64'h0);
    chk("areset_pend", {rd_pend_b, rd_pend_n}, 4'h0);
    chk("areset_pany", {pany_b, pany_n}, 2'b00);
    we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'h99;
    alloc_en = 1'b1; alloc_addr = 5'd5;
    rd(2'b11, 5'd5, 5'd10);
    tick();
    chk("reset_discard_data", rd_data_b, 64'h0);
    reset = 1'b0;
    idle(); rd(2'b11, 5'd5, 5'd10);
    tick();
    chk("post_reset_b", rd_data_b, 64'h0);
    chk("post_reset_n", rd_data_n, 64'h0);
    chk("post_reset_pend", {rd_pend_b, rd_pend_n}, 4'h0);
    chk("post_reset_pany", {pany_b, pany_n}, 2'b00);
    idle(); rd(2'b01, 5'd9, 5'd0);
    tick();
    chk("post_reset_r9", rd_data_b[31:0], 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parameterised multi-port register file, the next generation of the single-write, dual-read 32x32 file used by the datapath. It adds configurable width, depth and read-port count, and two write ports with fixed priority. It also adds optional write-to-read bypass, an optional hardwired zero register, and a per-register pending scoreboard so issue logic can detect outstanding writes. It sits between decode/issue (read and allocate side) and writeback (write side).

Parameters:
DATA_W, 32, data word width in bits
ADDR_W, 5, register address width; depth = 2**ADDR_W
NUM_RD, 2, number of read ports (1..4)
BYPASS, 1, 1 = same-cycle write data forwarded to read output; 0 = read returns pre-write contents
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and ignores allocation

Ports:
clk  input  1  clock; all state changes on rising edge
reset  input  1  asynchronous, active-high
we0  input  1  write enable, port 0
waddr0  input  ADDR_W  write address, port 0
wdata0  input  DATA_W  write data, port 0
we1  input  1  write enable, port 1 (higher priority)
waddr1  input  ADDR_W  write address, port 1
wdata1  input  DATA_W  write data, port 1
rd_en  input  NUM_RD  per-port read enable
rd_addr  input  NUM_RD*ADDR_W  packed read addresses; port k at bits [k*ADDR_W +: ADDR_W]
rd_data  output  NUM_RD*DATA_W  packed registered read data; port k at bits [k*DATA_W +: DATA_W]
rd_pending  output  NUM_RD  registered pending flag for each port's address
alloc_en  input  1  mark a register as awaiting a write
alloc_addr  input  ADDR_W  register to mark pending
pending_any  output  1  OR of all pending bits (registered state)

Behaviour:
- Reset (async, any time, including mid-operation): all registers = 0, all pending bits = 0, rd_data = 0, rd_pending = 0, pending_any = 0. Writes, allocations and reads presented while reset is high are discarded.
- Write:
  - At the rising edge, each enabled port writes its data.
  - If we0 and we1 are both set with waddr0 == waddr1, port 1 data is stored.
  - With ZERO_REG=1, writes to address 0 are dropped.
- Read:
  - Latency is 1 cycle. When rd_en[k] is high at an edge, rd_data[k] and rd_pending[k] update. When rd_en[k] is low, both hold their previous values.
  - Any number of ports may read the same address.
- Bypass:
  - BYPASS=1: if an enabled write targets rd_addr[k] in the same cycle, rd_data[k] takes that write's data (port 1 over port 0).
  - BYPASS=0: rd_data[k] takes the pre-edge contents.
  - ZERO_REG=1 with address 0: rd_data = 0 regardless of bypass.
- Scoreboard:
  - pending[a] next-state: set if alloc_en and alloc_addr == a; otherwise cleared if any enabled write hits a; otherwise held.
  - Alloc and write to the same address in the same cycle: pending stays set, because a new producer supersedes the current one.
  - With ZERO_REG=1, pending[0] is constant 0.
- rd_pending[k] samples pending[rd_addr[k]]:
  - BYPASS=1: samples the next-state value.
  - BYPASS=0: samples the pre-edge value.
  - In both cases it is consistent with rd_data[k].
- pending_any reflects the registered pending vector (1-cycle delay from alloc).
- No combinational path from any input to any output.

Decomposition:
- Shared package reg_file_pkg holds:
  - default DATA_W/ADDR_W localparams
  - the packed-port slice helper functions
  - the write-priority resolve function (returns hit flag and data for a given address), used by both the storage and the bypass logic
- One sub-module: reg_file_scoreboard (pending vector, alloc/clear priority, pending_any).
- Storage and read ports stay in reg_file_mp.

Test Plan:
1. Reset, then write 100 to r5 and 200 to r10 via we0 on consecutive edges; read r5 on port 0 and r10 on port 1 with rd_en=2'b11 -> one cycle later rd_data port0 = 100, port1 = 200.
2. Same cycle: we0 r7 = 0x11, we1 r7 = 0x22, port 0 reads r7 -> with BYPASS=1, rd_data = 0x22 next cycle, and a later read returns 0x22. Repeat with BYPASS=0 -> first read returns the old value 0; later read returns 0x22.
3. ZERO_REG=1: write 0xFFFF to r0 and alloc r0 -> reads of r0 return 0, rd_pending = 0, pending_any stays 0.
4. Alloc r3 -> pending_any = 1 next cycle, and a read of r3 gives rd_pending = 1. Write r3 = 5 -> pending clears. Alloc and write r3 in the same cycle -> pending remains 1.
5. Read r9 with rd_en=1, then drop rd_en and write r9 = 77 -> rd_data holds the old value until rd_en is reasserted, then shows 77.
6. Assert reset asynchronously between edges after writes and allocs -> rd_data, rd_pending and pending_any go to 0 immediately; subsequent reads of the written registers return 0.
